mem_dump_engine: RTL and testbench

- Synthesizable hex-dump engine: reads a memory region over an 8-bit single-port memory interface and streams a formatted ASCII hex dump, one byte per handshake.
- Sits beside the eJ32 core and memory so FPGA builds can dump TIB/OBUF contents to a UART without a simulator.
- Generalised over address width, bytes per row and byte-group size.
- Adds row buffering, output backpressure and address wrap-around.

---
 rtl/mem_dump_engine.sv | 193 +++++++++++++++++++
 tb/tb_mem_dump_engine.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_engine.sv
// Hex-dump engine: reads a memory region a row at a time into a local buffer and streams
// "\naddr: hhhhhhhh ...  ascii" lines over a valid/ready byte interface.
module mem_dump_engine #(
   parameter int unsigned ASZ = 17,
   parameter int unsigned ROW = 16,
   parameter int unsigned GRP = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [ASZ-1:0] addr_i,
   input  logic [ASZ-1:0] len_i,
   output logic           busy,
   output logic           done,
   output logic [ASZ-1:0] mem_addr,
   output logic           mem_rd,
   input  logic [7:0]     mem_data,
   output logic [7:0]     tx_data,
   output logic           tx_valid,
   input  logic           tx_ready
);
   localparam int unsigned ADIG = (ASZ + 3) / 4;
   localparam int unsigned RW   = $clog2(ROW);
   localparam int unsigned DW   = $clog2(ADIG) + 1;

   typedef enum logic [3:0] {
      StIdle, StFill, StNl, StAdr, StCol, StGsp, StHxh, StHxl, StSp2, StAsc
   } state_e;

   state_e            state;
   logic [ASZ-1:0]    rowaddr;
   logic [ASZ:0]      rows_left;
   logic [RW:0]       fk;
   logic [RW-1:0]     k;
   logic [RW-1:0]     k_nxt;
   logic [DW-1:0]     dig;
   logic [DW-1:0]     nib_idx;
   logic              sp;
   logic [7:0]        row_buf [ROW];
   logic [ASZ-1:0]    base;
   logic [ASZ:0]      span;
   logic [4*ADIG-1:0] addr_pad;
   logic [3:0]        adr_nib;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [7:0] asc_char(input logic [7:0] b);
      return (b < 8'h20 || b > 8'h7e) ? 8'h2e : b;
   endfunction

   // Span is one bit wider than an address so a full-memory length cannot overflow.
   always_comb begin
      base     = addr_i & ~ASZ'(ROW - 1);
      span     = (ASZ+1)'(len_i) + (ASZ+1)'(addr_i[RW-1:0]) + (ASZ+1)'(ROW - 1);
      k_nxt    = k + 1'b1;
      addr_pad = (4*ADIG)'(rowaddr);
      nib_idx  = (state == StNl) ? DW'(ADIG - 1) : dig - 1'b1;
      adr_nib  = addr_pad[{nib_idx, 2'b00} +: 4];
   end

   // Read data arrives one cycle after the strobe, so capture lags the FILL counter by one.
   always_ff @(posedge clk) begin
      if (state == StFill && fk != '0) row_buf[RW'(fk - 1'b1)] <= mem_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         rowaddr   <= '0;
         rows_left <= '0;
         fk        <= '0;
         k         <= '0;
         dig       <= '0;
         sp        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  if (len_i == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= StFill;
                     busy      <= 1'b1;
                     rowaddr   <= base;
                     rows_left <= span >> RW;
                     mem_addr  <= base;
                     mem_rd    <= 1'b1;
                     fk        <= '0;
                  end
               end
            end
            StFill: begin
               fk     <= fk + 1'b1;
               mem_rd <= (fk < (RW+1)'(ROW - 1));
               if (mem_rd) mem_addr <= mem_addr + 1'b1;
               if (fk == (RW+1)'(ROW)) begin
                  state    <= StNl;
                  tx_valid <= 1'b1;
                  tx_data  <= 8'h0a;
               end
            end
            default: begin
               if (tx_ready) begin
                  case (state)
                     StNl: begin
                        state   <= StAdr;
                        dig     <= DW'(ADIG - 1);
                        tx_data <= hex_char(adr_nib);
                     end
                     StAdr: begin
                        if (dig == '0) begin
                           state   <= StCol;
                           tx_data <= 8'h3a;
                        end else begin
                           dig     <= dig - 1'b1;
                           tx_data <= hex_char(adr_nib);
                        end
                     end
                     StCol: begin
                        state   <= StGsp;
                        k       <= '0;
                        tx_data <= 8'h20;
                     end
                     StGsp: begin
                        state   <= StHxh;
                        tx_data <= hex_char(row_buf[k][7:4]);
                     end
                     StHxh: begin
                        state   <= StHxl;
                        tx_data <= hex_char(row_buf[k][3:0]);
                     end
                     StHxl: begin
                        if (k == RW'(ROW - 1)) begin
                           state   <= StSp2;
                           sp      <= 1'b0;
                           tx_data <= 8'h20;
                        end else begin
                           k <= k_nxt;
                           if ((k_nxt & RW'(GRP - 1)) == '0) begin
                              state   <= StGsp;
                              tx_data <= 8'h20;
                           end else begin
                              state   <= StHxh;
                              tx_data <= hex_char(row_buf[k_nxt][7:4]);
                           end
                        end
                     end
                     StSp2: begin
                        if (!sp) begin
                           sp <= 1'b1;
                        end else begin
                           state   <= StAsc;
                           k       <= '0;
                           tx_data <= asc_char(row_buf[0]);
                        end
                     end
                     StAsc: begin
                        if (k == RW'(ROW - 1)) begin
                           tx_valid  <= 1'b0;
                           rows_left <= rows_left - 1'b1;
                           if (rows_left == (ASZ+1)'(1)) begin
                              state <= StIdle;
                              busy  <= 1'b0;
                              done  <= 1'b1;
                           end else begin
                              state    <= StFill;
                              rowaddr  <= rowaddr + ASZ'(ROW);
                              mem_addr <= rowaddr + ASZ'(ROW);
                              mem_rd   <= 1'b1;
                              fk       <= '0;
                           end
                        end else begin
                           k       <= k_nxt;
                           tx_data <= asc_char(row_buf[k_nxt]);
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dump_engine.sv
// Randomised bench for mem_dump_engine: a memory model feeds the DUT and every emitted
// character stream is compared against a string-formatting reference of the dump.
module tb_mem_dump_engine;
   localparam int unsigned ASZ   = 17;
   localparam int unsigned ROW   = 16;
   localparam int unsigned GRP   = 4;
   localparam int unsigned MEMSZ = 1 << ASZ;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [ASZ-1:0] addr_i = '0;
   logic [ASZ-1:0] len_i = '0;
   logic           busy, done, mem_rd, tx_valid;
   logic [ASZ-1:0] mem_addr;
   logic [7:0]     mem_data = '0;
   logic [7:0]     tx_data;
   logic           tx_ready = 1'b0;

   mem_dump_engine #(.ASZ(ASZ), .ROW(ROW), .GRP(GRP)) dut (
      .clk(clk), .rst(rst), .start(start), .addr_i(addr_i), .len_i(len_i),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [MEMSZ];
   byte unsigned rx_q[$];
   byte unsigned ref_q[$];
   int unsigned rd_q[$];
   int cyc = 0;
   int duty = 100;
   int n_chk = 0;
   int n_pass = 0;
   int start_cyc, first_rd_cyc, first_tx_cyc, last_tx_cyc, done_cyc;
   int done_cnt, stall_err, overlap, busy_seen;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic [7:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Data is valid exactly one cycle after the strobe; garbage otherwise.
   always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);

   always @(posedge clk) begin
      #1;
      tx_ready = (duty >= 100) || ($urandom_range(99) < duty);
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (mem_rd) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_q.push_back(int'(mem_addr));
            if (tx_valid) overlap++;
         end
         if (tx_valid && tx_ready) begin
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            last_tx_cyc = cyc;
            rx_q.push_back(tx_data);
         end
         if (prev_valid && !prev_ready && (!tx_valid || tx_data !== prev_data)) stall_err++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) busy_seen++;
         prev_valid = tx_valid;
         prev_ready = tx_ready;
         prev_data  = tx_data;
      end
   end

   function automatic void build_ref(input int unsigned a, input int unsigned l);
      int unsigned base, nrows, ra;
      string s;
      byte unsigned b;
      ref_q.delete();
      if (l == 0) return;
      base  = a & ~(ROW - 1);
      nrows = ((a - base) + l + ROW - 1) / ROW;
      for (int unsigned r = 0; r < nrows; r++) begin
         ra = (base + r * ROW) % MEMSZ;
         s  = $sformatf("\n%05x:", ra);
         for (int unsigned i = 0; i < ROW; i++) begin
            if (i % GRP == 0) s = {s, " "};
            s = {s, $sformatf("%02x", mem[(ra + i) % MEMSZ])};
         end
         s = {s, "  "};
         for (int unsigned i = 0; i < ROW; i++) begin
            b = mem[(ra + i) % MEMSZ];
            if (b < 8'h20 || b > 8'h7e) s = {s, "."};
            else s = {s, $sformatf("%c", b)};
         end
         for (int i = 0; i < s.len(); i++) ref_q.push_back(s[i]);
      end
   endfunction

   function automatic int stream_diff();
      int n;
      n = (rx_q.size() < ref_q.size()) ? rx_q.size() : ref_q.size();
      for (int i = 0; i < n; i++) if (rx_q[i] != ref_q[i]) return i;
      return (rx_q.size() == ref_q.size()) ? -1 : n;
   endfunction

   task automatic clear_mon();
      rx_q.delete();
      rd_q.delete();
      first_rd_cyc = -1;
      first_tx_cyc = -1;
      last_tx_cyc  = -1;
      done_cyc     = -1;
      done_cnt     = 0;
      busy_seen    = 0;
      stall_err    = 0;
      overlap      = 0;
   endtask

   // Runs one dump; a stray start is pulsed mid-run and the request inputs are scrambled
   // after acceptance, neither of which may affect the output.
   task automatic run_dump(input int unsigned a, input int unsigned l, input int d,
                           output bit to);
      duty = d;
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1;
      addr_i = ASZ'(a);
      len_i = ASZ'(l);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      addr_i = ASZ'($urandom);
      len_i = ASZ'($urandom);
      to = 1'b1;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (done) begin
            to = 1'b0;
            break;
         end
         if (n == 30) begin #2; start = 1'b1; end
         if (n == 31) begin #2; start = 1'b0; end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      build_ref(a, l);
   endtask

   task automatic test_reset();
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_chk++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %b want 0", mem_rd); else n_pass++;
      n_chk++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
      n_chk++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else n_pass++;
      n_chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else n_pass++;
   endtask

   task automatic test_aligned();
      bit to;
      int d;
      string exp_s;
      for (int i = 0; i < 16; i++) mem[32'h1000 + i] = 8'(i);
      run_dump(32'h1000, 32'h10, 100, to);
      exp_s = "\n01000: 00010203 04050607 08090a0b 0c0d0e0f  ................";
      n_chk++; if (to) $display("FAIL aligned_timeout got no done want done"); else n_pass++;
      n_chk++;
      if (rx_q.size() != 61) $display("FAIL aligned_len got %0d want 61", rx_q.size());
      else n_pass++;
      d = -1;
      for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++)
         if (d < 0 && rx_q[i] != exp_s[i]) d = i;
      n_chk++;
      if (d >= 0) $display("FAIL aligned_text at %0d got %h want %h", d, rx_q[d], exp_s[d]);
      else n_pass++;
      n_chk++;
      if (rd_q.size() != 16 || rd_q[0] != 32'h1000 || rd_q[15] != 32'h100f)
         $display("FAIL aligned_reads got %0d reads want 16 at 01000..0100f", rd_q.size());
      else n_pass++;
      n_chk++;
      if (first_rd_cyc != start_cyc + 1)
         $display("FAIL start_to_rd got %0d want %0d", first_rd_cyc - start_cyc, 1);
      else n_pass++;
      n_chk++;
      if (first_tx_cyc != first_rd_cyc + int'(ROW) + 1)
         $display("FAIL rd_to_tx got %0d want %0d", first_tx_cyc - first_rd_cyc, ROW + 1);
      else n_pass++;
      n_chk++;
      if (last_tx_cyc - first_tx_cyc != 60)
         $display("FAIL tx_rate got %0d want 60", last_tx_cyc - first_tx_cyc);
      else n_pass++;
      n_chk++;
      if (done_cnt != 1 || done_cyc != last_tx_cyc + 1)
         $display("FAIL aligned_done got cnt %0d cyc %0d want cnt 1 cyc %0d",
                  done_cnt, done_cyc, last_tx_cyc + 1);
      else n_pass++;
   endtask

   task automatic test_unaligned();
      bit to;
      int d;
      for (int i = 0; i < 32; i++) mem[32'h1000 + i] = 8'($urandom);
      run_dump(32'h1003, 32'h10, 100, to);
      d = stream_diff();
      n_chk++; if (to) $display("FAIL unaligned_timeout got no done want done"); else n_pass++;
      n_chk++;
      if (rx_q.size() != 122) $display("FAIL unaligned_len got %0d want 122", rx_q.size());
      else n_pass++;
      n_chk++; if (d >= 0) $display("FAIL unaligned_text at %0d got mismatch want match", d); else n_pass++;
      n_chk++;
      if (rd_q.size() != 32 || rd_q[0] != 32'h1000 || rd_q[16] != 32'h1010)
         $display("FAIL unaligned_reads got %0d reads want 32 from 01000/01010", rd_q.size());
      else n_pass++;
   endtask

   task automatic test_ascii();
      bit to;
      int d;
      string exp_s;
      for (int i = 0; i < 16; i++) mem[32'h2000 + i] = 8'($urandom);
      mem[32'h2000] = 8'h41;
      mem[32'h2001] = 8'h7e;
      mem[32'h2002] = 8'h7f;
      mem[32'h2003] = 8'h1f;
      mem[32'h2004] = 8'h20;
      run_dump(32'h2000, 5, 100, to);
      d = stream_diff();
      exp_s = "A~.. ";
      n_chk++; if (d >= 0 || to) $display("FAIL ascii_text at %0d got mismatch want match", d); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (rx_q.size() < 61 || rx_q[45 + i] != exp_s[i])
            $display("FAIL ascii_char%0d got %h want %h", i,
                     (rx_q.size() > 45 + i) ? rx_q[45 + i] : 8'h00, exp_s[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      bit to;
      int d;
      int unsigned a, l;
      for (int t = 0; t < 5; t++) begin
         a = $urandom_range(MEMSZ - 1);
         l = $urandom_range(48, 1);
         for (int unsigned i = 0; i < 80; i++) mem[(a - 16 + i) % MEMSZ] = 8'($urandom);
         run_dump(a, l, $urandom_range(100, 40), to);
         d = stream_diff();
         n_chk++;
         if (d >= 0 || to) $display("FAIL random%0d_text a=%h l=%0d at %0d got mismatch want match",
                                    t, a, l, d);
         else n_pass++;
         n_chk++;
         if (stall_err != 0 || overlap != 0)
            $display("FAIL random%0d_protocol got stall %0d overlap %0d want 0 0",
                     t, stall_err, overlap);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int d;
      for (int i = 0; i < 16; i++) mem[32'h1000 + i] = 8'(i);
      run_dump(32'h1000, 32'h10, 30, to);
      d = stream_diff();
      n_chk++; if (to) $display("FAIL bp_timeout got no done want done"); else n_pass++;
      n_chk++;
      if (rx_q.size() != 61 || d >= 0)
         $display("FAIL bp_text got len %0d diff %0d want len 61 match", rx_q.size(), d);
      else n_pass++;
      n_chk++; if (stall_err != 0) $display("FAIL bp_stable got %0d want 0", stall_err); else n_pass++;
      n_chk++; if (overlap != 0) $display("FAIL bp_overlap got %0d want 0", overlap); else n_pass++;
   endtask

   task automatic test_wrap_zero();
      bit to;
      int d;
      string a0, a1;
      string g0, g1;
      for (int unsigned i = 0; i < 16; i++) begin
         mem[MEMSZ - 16 + i] = 8'($urandom);
         mem[i] = 8'($urandom);
      end
      run_dump(32'h1fff0, 32'h20, 100, to);
      d = stream_diff();
      a0 = "1fff0";
      a1 = "00000";
      g0 = "";
      g1 = "";
      if (rx_q.size() >= 122)
         for (int i = 0; i < 5; i++) begin
            g0 = {g0, $sformatf("%c", rx_q[1 + i])};
            g1 = {g1, $sformatf("%c", rx_q[62 + i])};
         end
      n_chk++; if (d >= 0 || to) $display("FAIL wrap_text at %0d got mismatch want match", d); else n_pass++;
      n_chk++; if (g0 != a0) $display("FAIL wrap_row0 got '%s' want '%s'", g0, a0); else n_pass++;
      n_chk++; if (g1 != a1) $display("FAIL wrap_row1 got '%s' want '%s'", g1, a1); else n_pass++;
      n_chk++;
      if (rd_q.size() != 32 || rd_q[15] != MEMSZ - 1 || rd_q[16] != 0)
         $display("FAIL wrap_reads got %0d reads want 32 wrapping to 0", rd_q.size());
      else n_pass++;

      run_dump(32'h0abc, 0, 100, to);
      n_chk++;
      if (rx_q.size() != 0 || rd_q.size() != 0)
         $display("FAIL zero_quiet got %0d chars %0d reads want 0 0", rx_q.size(), rd_q.size());
      else n_pass++;
      n_chk++;
      if (to || done_cnt != 1 || done_cyc != start_cyc + 1)
         $display("FAIL zero_done got cnt %0d lat %0d want cnt 1 lat 1",
                  done_cnt, done_cyc - start_cyc);
      else n_pass++;
      n_chk++; if (busy_seen != 0) $display("FAIL zero_busy got %0d want 0", busy_seen); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to;
      int d;
      int dc;
      duty = 100;
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      addr_i = ASZ'(32'h1000);
      len_i = ASZ'(32'h20);
      @(posedge clk); #1;
      start = 1'b0;
      to = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         #1;
         if (rx_q.size() >= 10) begin
            to = 1'b0;
            break;
         end
      end
      n_chk++; if (to) $display("FAIL rmid_reach got no HXL want HXL"); else n_pass++;
      dc = done_cnt;
      rst = 1'b1;
      #1;
      n_chk++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0)
         $display("FAIL rmid_async got v%b b%b r%b want 0 0 0", tx_valid, busy, mem_rd);
      else n_pass++;
      @(posedge clk); #3;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      n_chk++; if (done_cnt != dc) $display("FAIL rmid_nodone got %0d want %0d", done_cnt, dc); else n_pass++;
      for (int i = 0; i < 16; i++) mem[32'h1000 + i] = 8'($urandom);
      run_dump(32'h1000, 32'h10, 100, to);
      d = stream_diff();
      n_chk++;
      if (to || d >= 0 || rx_q.size() != 61)
         $display("FAIL rmid_redump got len %0d diff %0d want len 61 match", rx_q.size(), d);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < int'(MEMSZ); i++) mem[i] = 8'($urandom);
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_aligned();
      test_unaligned();
      test_ascii();
      test_random();
      test_backpressure();
      test_wrap_zero();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
